boot_seq_ctrl: RTL and testbench

//  Boot/run sequencer for the single-cycle RISC-V core. Holds the core in reset,

---
 rtl/boot_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_boot_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: holds the core in reset, loads a byte-streamed image into imem, then releases it.
// Optional single-step clock enable when STEP_EN is defined.
module boot_seq_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              cpu_clk_en_o,
  output logic              busy_o,
  output logic              err_o,
  input  logic              step_mode_i,
  input  logic              step_i
);

  // state | meaning
  // IDLE  | core held, waiting for load_req or start
  // HDR   | waiting for word-count byte (N-1)
  // LOAD  | assembling and writing words
  // RUN   | core released
  // ERR   | inter-byte timeout, core held
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_RUN, S_ERR} state_t;

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] nwords_q, nwords_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              done_q, done_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              cpu_clk_en_q, cpu_clk_en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              accept, tmo_tc;

  assign accept = byte_valid_i & byte_ready_q;
  assign tmo_tc = (tmo_q == '0);

`ifdef STEP_EN
  logic step_q, step_rise;
  assign step_rise = step_i & ~step_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) step_q <= 1'b0;
    else       step_q <= step_i;
  end
`else
  logic unused_step;
  assign unused_step = step_mode_i ^ step_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load_req_i) state_d = S_HDR;
              else if (start_i) state_d = S_RUN;
      S_HDR:  if (load_req_i) state_d = S_HDR;
              else if (accept) state_d = S_LOAD;
              else if (tmo_tc) state_d = S_ERR;
      S_LOAD: if (load_req_i) state_d = S_HDR;
              else if (done_q) state_d = S_RUN;
              else if (!accept && tmo_tc) state_d = S_ERR;
      S_RUN:  if (load_req_i) state_d = S_HDR;
      S_ERR:  if (load_req_i) state_d = S_HDR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs are both derived here so outputs track state_q exactly.
  always_comb begin
    tmo_d        = tmo_q;
    nwords_d     = nwords_q;
    ptr_d        = ptr_q;
    bcnt_d       = bcnt_q;
    asm_d        = asm_q;
    done_d       = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (load_req_i) begin
      tmo_d  = TMO_LOAD;
      ptr_d  = '0;
      bcnt_d = '0;
      asm_d  = '0;
    end else if (state_q == S_HDR || state_q == S_LOAD) begin
      if (accept)       tmo_d = TMO_LOAD;
      else if (!tmo_tc) tmo_d = tmo_q - TMO_W'(1);
      if (accept && state_q == S_HDR) begin
        nwords_d = ADDR_W'(byte_data_i);
        ptr_d    = '0;
        bcnt_d   = '0;
      end else if (accept) begin
        if (bcnt_q == 2'd3) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = {byte_data_i, asm_q};
          ptr_d        = ptr_q + ADDR_W'(1);
          bcnt_d       = '0;
          done_d       = (ptr_q == nwords_q);
        end else begin
          asm_d[{bcnt_q, 3'b000} +: 8] = byte_data_i;
          bcnt_d = bcnt_q + 2'd1;
        end
      end
    end
    busy_d       = (state_d == S_HDR) || (state_d == S_LOAD);
    byte_ready_d = busy_d && !done_d;
    err_d        = (state_d == S_ERR);
    cpu_rst_n_d  = (state_d == S_RUN);
`ifdef STEP_EN
    cpu_clk_en_d = (state_d == S_RUN) && (!step_mode_i || step_rise);
`else
    cpu_clk_en_d = (state_d == S_RUN);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q        <= '0;
      nwords_q     <= '0;
      ptr_q        <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      done_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_clk_en_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      nwords_q     <= nwords_d;
      ptr_q        <= ptr_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      done_q       <= done_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_clk_en_q <= cpu_clk_en_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign cpu_clk_en_o = cpu_clk_en_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Testbench for boot_seq_ctrl: vector table, directed corner sequences and randomized image loads.
module tb_boot_seq_ctrl;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        step_mode = 1'b0, step = 1'b0;
  logic        byte_ready, imem_we, cpu_rst_n, cpu_clk_en, busy, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  q_addr[$];
  logic [31:0] q_data[$];

  boot_seq_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .start_i(start),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_rst_n_o(cpu_rst_n), .cpu_clk_en_o(cpu_clk_en), .busy_o(busy), .err_o(err),
    .step_mode_i(step_mode), .step_i(step)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected (addr, word).
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (q_data.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", imem_addr, imem_wdata);
      end else begin
        chk("write_addr", {24'h0, imem_addr}, {24'h0, q_addr.pop_front()});
        chk("write_data", imem_wdata, q_data.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      rdy = byte_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  task automatic wait_run(input string nm);
    for (int i = 0; i < 10; i++) begin
      if (cpu_rst_n) break;
      tick();
    end
    chk({nm, "_rst_n"}, {31'h0, cpu_rst_n}, 32'd1);
    chk({nm, "_busy"}, {31'h0, busy}, 32'd0);
  endtask

  typedef struct {
    logic       lr, st, bv;
    logic [7:0] bd;
    logic       busy, rstn, rdy, err, we, ce;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset, then idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_cpu_rst_n", {31'h0, cpu_rst_n}, 32'd0);
    chk("rst_byte_ready", {31'h0, byte_ready}, 32'd0);
    chk("rst_flags", {28'h0, imem_we, cpu_clk_en, busy, err}, 32'd0);
    chk("rst_addr", {24'h0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);

    // Vector table: simultaneous load_req/start, one-word load, RUN re-hold, partial abort
    expect_write(8'h00, 32'h0050_0013);
    for (int i = 0; i < 13; i++) begin
      load_req = tbl[i].lr; start = tbl[i].st; byte_valid = tbl[i].bv; byte_data = tbl[i].bd;
      tick();
      chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].busy});
      chk($sformatf("vec%0d_rst_n", i), {31'h0, cpu_rst_n}, {31'h0, tbl[i].rstn});
      chk($sformatf("vec%0d_ready", i), {31'h0, byte_ready}, {31'h0, tbl[i].rdy});
      chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, tbl[i].err});
      chk($sformatf("vec%0d_we", i), {31'h0, imem_we}, {31'h0, tbl[i].we});
      chk($sformatf("vec%0d_clk_en", i), {31'h0, cpu_clk_en}, {31'h0, tbl[i].ce});
    end
    load_req = 1'b0; start = 1'b0; byte_valid = 1'b0;

    // Two-word image
    expect_write(8'h00, 32'h0050_0013);
    expect_write(8'h01, 32'h0010_0093);
    pulse_load();
    send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    wait_run("t2");

    // Abort with a partial word, then a fresh one-word load
    pulse_load();
    send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    pulse_load();
    chk("t3_busy", {31'h0, busy}, 32'd1);
    chk("t3_no_we", {31'h0, imem_we}, 32'd0);
    expect_write(8'h00, 32'hCAFE_F00D);
    send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    wait_run("t3");

    // Timeout fires after TO idle cycles
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (TO - 1) tick();
    chk("t4_pre_err", {31'h0, err}, 32'd0);
    chk("t4_pre_busy", {31'h0, busy}, 32'd1);
    tick();
    chk("t4_err", {31'h0, err}, 32'd1);
    chk("t4_err_rst_n", {31'h0, cpu_rst_n}, 32'd0);
    chk("t4_err_busy", {31'h0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_start_ignored", {30'h0, err, cpu_rst_n}, 32'd2);
    pulse_load();
    chk("t4_reload_err", {31'h0, err}, 32'd0);
    chk("t4_reload_busy", {31'h0, busy}, 32'd1);

    // Byte on the terminal-count cycle is taken
    expect_write(8'h00, 32'h4433_2211);
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (TO - 1) tick();
    send_byte(8'h22);
    chk("t4_tc_err", {31'h0, err}, 32'd0);
    chk("t4_tc_busy", {31'h0, busy}, 32'd1);
    send_byte(8'h33); send_byte(8'h44);
    wait_run("t4_tc");

    // Randomized loads checked against a transaction-level model
    for (int it = 0; it < 25; it++) begin
      int          n, abort_k, sent;
      bit          aborted;
      logic [31:0] w;
      n       = $urandom_range(1, 5);
      abort_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * n) : -1;
      aborted = 1'b0;
      start   = $urandom_range(0, 1) == 1;
      pulse_load();
      start = 1'b0;
      send_byte(8'(n - 1));
      sent = 1;
      for (int wi = 0; wi < n && !aborted; wi++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) begin
          if (sent == abort_k) begin
            aborted = 1'b1;
            break;
          end
          repeat ($urandom_range(0, 2)) begin
            start = $urandom_range(0, 1) == 1;
            tick();
          end
          start = 1'b0;
          if (b == 3) expect_write(8'(wi), w);
          send_byte(w[8*b +: 8]);
          sent++;
        end
      end
      if (aborted) begin
        pulse_load();
        chk($sformatf("rnd%0d_abort_busy", it), {31'h0, busy}, 32'd1);
      end else begin
        wait_run($sformatf("rnd%0d", it));
        chk($sformatf("rnd%0d_err", it), {31'h0, err}, 32'd0);
      end
    end

    // Single-step clock enable in RUN
    expect_write(8'h00, 32'h0000_0013);
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_run("t6");
    begin
      int ce_cnt;
      ce_cnt = 0;
      step_mode = 1'b1;
      for (int p = 0; p < 3; p++) begin
        step = 1'b1;
        tick(); ce_cnt += int'(cpu_clk_en);
        tick(); ce_cnt += int'(cpu_clk_en);
        step = 1'b0;
        repeat (3) begin
          tick(); ce_cnt += int'(cpu_clk_en);
        end
      end
`ifdef STEP_EN
      chk("t6_step_cycles", ce_cnt, 32'd3);
`else
      chk("t6_step_ignored", ce_cnt, 32'd15);
`endif
      step_mode = 1'b0;
    end

    // Asynchronous reset mid-load
    pulse_load();
    send_byte(8'h02);
    send_byte(8'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'h0, busy}, 32'd0);
    chk("async_rst_ready", {31'h0, byte_ready}, 32'd0);
    chk("async_rst_rst_n", {31'h0, cpu_rst_n}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {29'h0, busy, err, cpu_rst_n}, 32'd0);

    chk("scoreboard_empty", q_data.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
